// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   Pipelined immediate generator for the decode stage. Takes a 32-bit
//   instruction, extracts the I/S/B/J/U immediate, sign-extends it to XLEN
//   bits and flags formats that carry no immediate. The immediate format
//   comes either from imm_src or, with AUTO_DECODE=1, from the opcode.
//   A two-entry buffer (main + skid) gives full throughput while keeping
//   in_ready a plain flop with no path from out_ready.
//
// Parameters
//   XLEN        output immediate width (32 or 64)
//   AUTO_DECODE 0: format from imm_src, 1: format from instr[6:0]
//   TAG_W       width of the sideband tag
//
// Ports
//   clk, rst_n                 clock / asynchronous active-low reset
//   in_valid, in_ready         input handshake
//   instr, imm_src, in_tag     instruction, explicit format, sideband tag
//   out_valid, out_ready       output handshake
//   out_imm, out_illegal       sign-extended immediate, no-immediate flag
//   out_tag                    tag of the transaction on the output
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
   parameter int XLEN        = 32,
   parameter bit AUTO_DECODE = 1'b0,
   parameter int TAG_W       = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [2:0]       imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // main invalid
      ONE   = 2'd1,   // main valid
      FULL  = 2'd2    // main and skid valid
   } state_t;

   localparam logic [2:0] FMT_I   = 3'b000;
   localparam logic [2:0] FMT_S   = 3'b001;
   localparam logic [2:0] FMT_B   = 3'b010;
   localparam logic [2:0] FMT_J   = 3'b011;
   localparam logic [2:0] FMT_U   = 3'b100;
   localparam logic [2:0] FMT_BAD = 3'b111;

   // ---------------------------------------------------------------------
   // Format selection
   // ---------------------------------------------------------------------
   logic [2:0] fmt;

   generate
      if (AUTO_DECODE) begin : g_auto
         logic unused_src;
         assign unused_src = ^imm_src;

         always_comb begin
            fmt = FMT_BAD;
            case (instr[6:0])
               7'b0000011,
               7'b0010011,
               7'b1100111: fmt = FMT_I;
               7'b0100011: fmt = FMT_S;
               7'b1100011: fmt = FMT_B;
               7'b1101111: fmt = FMT_J;
               7'b0110111,
               7'b0010111: fmt = FMT_U;
               default:    fmt = FMT_BAD;
            endcase
         end
      end else begin : g_explicit
         // The opcode field never contributes to any immediate.
         logic unused_opcode;
         assign unused_opcode = ^instr[6:0];
         assign fmt = imm_src;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Immediate extraction (32-bit, already sign-extended from instr[31])
   // ---------------------------------------------------------------------
   logic [31:0] imm32;
   logic        illegal_new;

   always_comb begin
      imm32       = '0;
      illegal_new = 1'b0;
      case (fmt)
         FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
         FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
         FMT_U: imm32 = {instr[31:12], 12'b0};
         default: begin
            imm32       = '0;
            illegal_new = 1'b1;
         end
      endcase
   end

   logic [XLEN-1:0] imm_new;

   generate
      if (XLEN > 32) begin : g_wide
         assign imm_new = {{(XLEN-32){imm32[31]}}, imm32};
      end else begin : g_narrow
         assign imm_new = imm32;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Buffer control
   // ---------------------------------------------------------------------
   state_t state_reg, state_next;
   logic   in_ready_reg;
   logic   accept, pop;
   logic   load_main, load_skid, skid_to_main;

   assign accept = in_valid & in_ready_reg;
   assign pop    = out_valid & out_ready;

   always_comb begin
      state_next   = state_reg;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               state_next = ONE;
               load_main  = 1'b1;
            end
         end
         ONE: begin
            if (accept && pop) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_next = FULL;
               load_skid  = 1'b1;
            end else if (pop) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_next   = ONE;
               skid_to_main = 1'b1;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= EMPTY;
         in_ready_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         // Ready is just "skid will be empty", computed one cycle ahead.
         in_ready_reg <= (state_next != FULL);
      end
   end

   // ---------------------------------------------------------------------
   // Data registers
   // ---------------------------------------------------------------------
   logic [XLEN-1:0]  main_imm, skid_imm;
   logic             main_illegal, skid_illegal;
   logic [TAG_W-1:0] main_tag, skid_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_imm     <= '0;
         main_illegal <= 1'b0;
         main_tag     <= '0;
      end else if (load_main) begin
         main_imm     <= imm_new;
         main_illegal <= illegal_new;
         main_tag     <= in_tag;
      end else if (skid_to_main) begin
         main_imm     <= skid_imm;
         main_illegal <= skid_illegal;
         main_tag     <= skid_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_imm     <= '0;
         skid_illegal <= 1'b0;
         skid_tag     <= '0;
      end else if (load_skid) begin
         skid_imm     <= imm_new;
         skid_illegal <= illegal_new;
         skid_tag     <= in_tag;
      end
   end

   // Main register holds its contents after a pop, so outputs keep their
   // last value while out_valid is low.
   assign in_ready    = in_ready_reg;
   assign out_valid   = (state_reg != EMPTY);
   assign out_imm     = main_imm;
   assign out_illegal = main_illegal;
   assign out_tag     = main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//   Directed bench for imm_gen_pipe. Three instances share the stimulus:
//   u0 (XLEN=32, explicit format), u1 (XLEN=64, explicit format) and
//   u2 (XLEN=32, opcode-decoded format). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [2:0]  imm_src;
   logic [4:0]  in_tag;

   logic        rdy0, rdy1, rdy2;
   logic        v0, v1, v2;
   logic [31:0] imm0, imm2;
   logic [63:0] imm1;
   logic        ill0, ill1, ill2;
   logic [4:0]  tag0, tag1, tag2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(5)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
      .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
      .out_valid(v0), .out_ready(out_ready), .out_imm(imm0),
      .out_illegal(ill0), .out_tag(tag0)
   );

   imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b0), .TAG_W(5)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
      .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
      .out_valid(v1), .out_ready(out_ready), .out_imm(imm1),
      .out_illegal(ill1), .out_tag(tag1)
   );

   imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1), .TAG_W(5)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
      .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
      .out_valid(v2), .out_ready(out_ready), .out_imm(imm2),
      .out_illegal(ill2), .out_tag(tag2)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   // One beat with out_ready=1: drive on a falling edge, check one cycle later.
   task automatic vec(input string name, input logic [31:0] ins, input logic [2:0] src,
                      input logic [4:0] tg,
                      input logic [31:0] e0, input logic e0i,
                      input logic [63:0] e1, input logic e1i,
                      input logic [31:0] e2, input logic e2i);
      @(negedge clk);
      chk({name, ".in_ready"}, {63'd0, rdy0}, 64'd1);
      instr    = ins;
      imm_src  = src;
      in_tag   = tg;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk({name, ".valid"},   {63'd0, v0},   64'd1);
      chk({name, ".imm32"},   {32'd0, imm0}, {32'd0, e0});
      chk({name, ".ill32"},   {63'd0, ill0}, {63'd0, e0i});
      chk({name, ".tag"},     {59'd0, tag0}, {59'd0, tg});
      chk({name, ".imm64"},   imm1,          e1);
      chk({name, ".ill64"},   {63'd0, ill1}, {63'd0, e1i});
      chk({name, ".valid_a"}, {63'd0, v2},   64'd1);
      chk({name, ".imm_a"},   {32'd0, imm2}, {32'd0, e2});
      chk({name, ".ill_a"},   {63'd0, ill2}, {63'd0, e2i});
      $display("txn %s instr=%08h src=%0d -> imm32=%08h ill=%0d imm64=%016h auto=%08h/%0d",
               name, ins, src, imm0, ill0, imm1, imm2, ill2);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      instr     = '0;
      imm_src   = '0;
      in_tag    = '0;

      // Reset state
      #12;
      chk("rst.valid", {63'd0, v0},   64'd0);
      chk("rst.ready", {63'd0, rdy0}, 64'd1);
      chk("rst.imm",   {32'd0, imm0}, 64'd0);
      chk("rst.ill",   {63'd0, ill0}, 64'd0);
      chk("rst.tag",   {59'd0, tag0}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Formats
      vec("I",  32'hFFF00093, 3'b000, 5'd3,
          32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0);
      vec("S",  32'hFE20AE23, 3'b001, 5'd4,
          32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0);
      vec("B",  32'h00000463, 3'b010, 5'd5,
          32'h00000008, 1'b0, 64'h0000000000000008, 1'b0, 32'h00000008, 1'b0);
      vec("J",  32'hFFFFF06F, 3'b011, 5'd6,
          32'hFFFFFFFE, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b0, 32'hFFFFFFFE, 1'b0);
      vec("U+", 32'h123450B7, 3'b100, 5'd7,
          32'h12345000, 1'b0, 64'h0000000012345000, 1'b0, 32'h12345000, 1'b0);
      vec("U-", 32'hABCDE0B7, 3'b100, 5'd8,
          32'hABCDE000, 1'b0, 64'hFFFFFFFFABCDE000, 1'b0, 32'hABCDE000, 1'b0);
      // add: explicit I still extracts bits 31:20, auto-decode flags it
      vec("R",  32'h002081B3, 3'b000, 5'd9,
          32'h00000002, 1'b0, 64'h0000000000000002, 1'b0, 32'h00000000, 1'b1);
      // imm_src 101 illegal when explicit; auto-decode ignores it (B opcode)
      vec("BAD", 32'h00000463, 3'b101, 5'd10,
          32'h00000000, 1'b1, 64'h0000000000000000, 1'b1, 32'h00000008, 1'b0);

      // Outputs hold after the last beat has drained
      @(negedge clk);
      chk("hold.valid", {63'd0, v0},   64'd0);
      chk("hold.tag",   {59'd0, tag0}, 64'd10);
      chk("hold.ill",   {63'd0, ill0}, 64'd1);

      // Backpressure: tags 1,2 fill the buffer, tag 3 waits
      out_ready = 1'b0;
      instr = {12'd1, 20'h00013}; imm_src = 3'b000; in_tag = 5'd1; in_valid = 1'b1;
      @(negedge clk);
      chk("bp.ready1", {63'd0, rdy0}, 64'd1);
      chk("bp.tag1",   {59'd0, tag0}, 64'd1);
      instr = {12'd2, 20'h00013}; in_tag = 5'd2;
      @(negedge clk);
      chk("bp.ready_full", {63'd0, rdy0}, 64'd0);
      instr = {12'd3, 20'h00013}; in_tag = 5'd3;
      @(negedge clk);
      chk("bp.held_ready", {63'd0, rdy0}, 64'd0);
      chk("bp.stable_tag", {59'd0, tag0}, 64'd1);
      chk("bp.stable_imm", {32'd0, imm0}, 64'd1);
      $display("txn bp stalled: tag=%0d in_ready=%0d", tag0, rdy0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp.out2_valid", {63'd0, v0},   64'd1);
      chk("bp.out2_tag",   {59'd0, tag0}, 64'd2);
      chk("bp.out2_imm",   {32'd0, imm0}, 64'd2);
      chk("bp.ready_back", {63'd0, rdy0}, 64'd1);
      $display("txn bp out tag=%0d", tag0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp.out3_valid", {63'd0, v0},   64'd1);
      chk("bp.out3_tag",   {59'd0, tag0}, 64'd3);
      chk("bp.out3_imm",   {32'd0, imm0}, 64'd3);
      $display("txn bp out tag=%0d", tag0);
      @(negedge clk);
      chk("bp.drained", {63'd0, v0}, 64'd0);

      // Asynchronous reset while FULL
      out_ready = 1'b0;
      instr = 32'hFFF00093; imm_src = 3'b000; in_tag = 5'd11; in_valid = 1'b1;
      @(negedge clk);
      in_tag = 5'd12;
      @(negedge clk);
      in_valid = 1'b0;
      chk("ar.full", {63'd0, rdy0}, 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.valid", {63'd0, v0},   64'd0);
      chk("ar.imm",   {32'd0, imm0}, 64'd0);
      chk("ar.ill",   {63'd0, ill0}, 64'd0);
      chk("ar.tag",   {59'd0, tag0}, 64'd0);
      chk("ar.ready", {63'd0, rdy0}, 64'd1);
      $display("txn async reset while full: valid=%0d ready=%0d", v0, rdy0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      vec("post_rst", 32'hFFF00093, 3'b000, 5'd13,
          32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
